// File: rtl/capuccino_pkg.sv
// Shared definitions for the capuccino mixer family.
//   AMT_W          : width of every amount (bebida, planchuela, lala, counters)
//   MAX_BEBIDA_DEF : default largest accepted bebida request
//   state_t        : dispenser FSM states
package capuccino_pkg;
  localparam int AMT_W          = 8;
  localparam int MAX_BEBIDA_DEF = 250;

  typedef logic [AMT_W-1:0] amt_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LALA,
    PLANCHUELA,
    DONE,
    ERROR
  } state_t;
endpackage

// File: rtl/capuccino_dosificador.sv
// dosificador: saturating step counter for one ingredient.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear count (new order accepted)
//   en       : valve open this cycle, advance by PASO (or by what is left)
//   tgt      : amount to reach
//   cnt      : amount delivered so far
//   llego    : the step taken this cycle lands exactly on tgt
module dosificador
  import capuccino_pkg::*;
#(
  parameter int PASO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  amt_t tgt,
  output amt_t cnt,
  output logic llego
);
  localparam amt_t STEP = AMT_W'(PASO);

  amt_t resto;

  assign resto = tgt - cnt;
  // Remaining amount fits in one step: this is the final (possibly partial) step.
  assign llego = (resto <= STEP);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= llego ? tgt : cnt + STEP;
  end
endmodule

// File: rtl/capuccino_dispensador.sv
// capuccino_dispensador: splits a requested bebida into lala (milk) and
// planchuela (coffee) and meters each out through its valve, PASO units/cycle.
// Milk first, then coffee; valves never overlap. All outputs registered.
//   clk, rst             : clock, synchronous active-high reset
//   start                : order strobe, sampled only in IDLE
//   bebida, planchuela   : order amounts, captured on accepted start
//   busy                 : order in flight (CHECK..DONE/ERROR)
//   valvula_lala/_planchuela : valve drives
//   lala_cnt, planchuela_cnt : amounts dispensed in the current order
//   done, error          : one-cycle completion / rejection pulses
module capuccino_dispensador
  import capuccino_pkg::*;
#(
  parameter int PASO       = 1,
  parameter int MAX_BEBIDA = MAX_BEBIDA_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] bebida,
  input  logic [AMT_W-1:0] planchuela,
  output logic             busy,
  output logic             valvula_lala,
  output logic             valvula_planchuela,
  output logic [AMT_W-1:0] lala_cnt,
  output logic [AMT_W-1:0] planchuela_cnt,
  output logic             done,
  output logic             error
);
  localparam amt_t MAX_B = AMT_W'(MAX_BEBIDA);

  state_t state, state_n;
  amt_t   bebida_tgt, planchuela_tgt, lala_tgt, diff;
  logic   rechazo, aceptar;
  logic   lala_llego, planchuela_llego;

  assign aceptar = (state == IDLE) && start;
  assign rechazo = (planchuela_tgt > bebida_tgt) || (bebida_tgt > MAX_B);
  assign diff    = bebida_tgt - planchuela_tgt;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (start) state_n = CHECK;
      CHECK: begin
        if (rechazo)                   state_n = ERROR;
        else if (diff != '0)           state_n = LALA;
        else if (planchuela_tgt != '0) state_n = PLANCHUELA;
        else                           state_n = DONE;
      end
      LALA:       if (lala_llego)
                    state_n = (planchuela_tgt != '0) ? PLANCHUELA : DONE;
      PLANCHUELA: if (planchuela_llego) state_n = DONE;
      DONE:       state_n = IDLE;
      ERROR:      state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bebida_tgt         <= '0;
      planchuela_tgt     <= '0;
      lala_tgt           <= '0;
      busy               <= 1'b0;
      valvula_lala       <= 1'b0;
      valvula_planchuela <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      state <= state_n;
      if (aceptar) begin
        bebida_tgt     <= bebida;
        planchuela_tgt <= planchuela;
        lala_tgt       <= '0;
      end
      if (state == CHECK && !rechazo)
        lala_tgt <= diff;
      // Outputs follow the state being entered so they line up with it.
      busy               <= (state_n != IDLE);
      valvula_lala       <= (state_n == LALA);
      valvula_planchuela <= (state_n == PLANCHUELA);
      done               <= (state_n == DONE);
      error              <= (state_n == ERROR);
    end
  end

  dosificador #(.PASO(PASO)) u_lala (
    .clk   (clk),
    .rst   (rst),
    .clr   (aceptar),
    .en    (state == LALA),
    .tgt   (lala_tgt),
    .cnt   (lala_cnt),
    .llego (lala_llego)
  );

  dosificador #(.PASO(PASO)) u_planchuela (
    .clk   (clk),
    .rst   (rst),
    .clr   (aceptar),
    .en    (state == PLANCHUELA),
    .tgt   (planchuela_tgt),
    .cnt   (planchuela_cnt),
    .llego (planchuela_llego)
  );
endmodule

// File: doc/capuccino_dispensador.md
Name: capuccino_dispensador

Overview:
- Sequential inverse of the combinational `capuccino` mixer: that block adds `lala` + `planchuela` into `bebida`; this block takes a requested `bebida` total plus the `planchuela` share and splits it back out.
- Computes `lala = bebida - planchuela`, then meters out each ingredient over time by driving one valve per ingredient, `PASO` units per clock.
- Sits between the order interface (start/done handshake) and the valve actuators; its counters feed the display/accounting logic.

Parameters:
- PASO, 1, units dispensed per active valve cycle (1..255).
- MAX_BEBIDA, 250, largest accepted `bebida` request; larger requests are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- bebida  input  8  requested total amount; captured on accepted start.
- planchuela  input  8  coffee share; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE/ERROR is exited.
- valvula_lala  output  1  milk valve open; one cycle = PASO units (the last cycle may deliver fewer).
- valvula_planchuela  output  1  coffee valve open.
- lala_cnt  output  8  milk dispensed so far in the current order.
- planchuela_cnt  output  8  coffee dispensed so far in the current order.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, both valves, done and error go to 0.
  - lala_cnt, planchuela_cnt and the captured targets go to 0.
  - Reset overrides everything, including mid-dispense: the valves close on that same edge and the order is abandoned.
- FSM states: IDLE, CHECK, LALA, PLANCHUELA, DONE, ERROR. Outputs are registered.
- IDLE:
  - On start=1, capture bebida and planchuela into targets.
  - Clear both counters.
  - Go to CHECK.
  - start in any other state is ignored; there is no queueing.
- CHECK (1 cycle, busy=1):
  - If planchuela > bebida or bebida > MAX_BEBIDA, go to ERROR.
  - Otherwise register lala_tgt = bebida - planchuela (8-bit, no underflow possible after the check).
  - Then go to LALA if lala_tgt ≠ 0, else PLANCHUELA if planchuela_tgt ≠ 0, else DONE.
- LALA:
  - valvula_lala=1 each cycle.
  - lala_cnt += min(PASO, lala_tgt - lala_cnt), so the count saturates exactly at the target and never wraps.
  - When the post-update count equals lala_tgt, go to PLANCHUELA (or to DONE if planchuela_tgt=0).
  - The valve stays high for the final partial step.
- PLANCHUELA: same rules using planchuela_cnt and planchuela_tgt; ends in DONE.
  - Milk is always dispensed before coffee.
  - The two valves are never high in the same cycle.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. The counters hold their final values until the next accepted start.
- ERROR: error=1 for one cycle, no valve ever opened, counters stay 0, return to IDLE.
- Latency:
  - The accepting edge moves the FSM IDLE→CHECK.
  - Valve cycles = ceil(lala_tgt/PASO) + ceil(planchuela_tgt/PASO).
  - The done pulse follows in the next cycle.
  - With PASO=1: total = 1 + lala + planchuela + 1 cycles after the accepting edge.
- Boundary cases:
  - bebida=0, planchuela=0: CHECK→DONE, no valve activity.
  - planchuela = bebida: LALA skipped.
  - planchuela = 0: PLANCHUELA skipped.
  - start held high continuously: a new order is accepted on the first IDLE cycle after DONE/ERROR.

Decomposition:
- Shared package `capuccino_pkg` holds:
  - the state enum;
  - MAX_BEBIDA_DEF=250 and the 8-bit amount width constant, also reused by `capuccino`.
- One natural sub-module: `dosificador`, a saturating step counter with inputs clk, rst, clr, en, tgt[7:0] and outputs cnt[7:0], llego.
  - Instantiate it twice, once per ingredient; the FSM sequences them.

Test Plan:
- bebida=182, planchuela=165, PASO=1 -> valvula_lala high 17 cycles, then valvula_planchuela high 165 cycles, done pulse; final lala_cnt=17, planchuela_cnt=165.
- bebida=116, planchuela=99, PASO=4 -> lala 5 cycles (4,8,12,16,17), planchuela 25 cycles ending at 99, done once, valves never overlap.
- bebida=100, planchuela=200 -> error pulse 2 cycles after start, no valve activity, counters 0; bebida=251 -> error likewise.
- bebida=0, planchuela=0 -> done 2 cycles after start with no valves; bebida=50, planchuela=50 -> only the planchuela valve, 50 cycles.
- rst asserted for one cycle mid-LALA (lala_cnt=8) -> the next cycle shows IDLE with all outputs and counters 0; a subsequent start with 182/165 completes normally.
- start pulsed while busy with different values -> ignored; the original order completes with its captured targets.
